sync_mem_stream_reader: RTL
===========================

# sync_mem_stream_reader

Read sequencer that sits directly upstream of a `coreir_sync_read_mem` instance (such as the `Memory` wrapper). It drives the memory's `RADDR`/`RE` and consumes `RDATA`, which arrives one cycle after the read is issued. It turns a burst request (base address, count) into a valid/ready output stream with full backpressure and full throughput. Typical use: streaming coefficient or lookup tables out of an initialised ROM into a downstream datapath.

## Interface
Parameters:
- `WIDTH`, default 5: data width; must match the memory width.
- `DEPTH`, default 4: memory depth. `AW = max(1, $clog2(DEPTH))` is the address width. `CW = $clog2(DEPTH+1)` is the count width.

Ports:
- `CLK` input 1: single clock; all state updates on the rising edge.
- `RESET` input 1: synchronous, active-high reset.
- `START` input 1: burst request; sampled only when `BUSY`=0.
- `BASE` input AW: first address of the burst.
- `COUNT` input CW: number of words to read, 0..DEPTH.
- `BUSY` output 1: burst in progress.
- `DONE` output 1: one-cycle pulse when a burst completes.
- `RADDR` output AW: memory read address.
- `RE` output 1: memory read enable.
- `RDATA` input WIDTH: memory read data, valid the cycle after `RE`=1.
- `OUT_DATA` output WIDTH: stream data.
- `OUT_VALID` output 1: stream valid.
- `OUT_READY` input 1: stream ready.

## Operation
- **State.** The block holds:
  - `addr` (AW bits) and `remaining` (CW bits): words still to issue.
  - `inflight`: one bit, a registered copy of `RE`.
  - a 3-entry output FIFO holding `fcount` entries (0..3).
  - a `left` counter: words not yet handed off downstream.
- **Idle** (`BUSY`=0): when `START`=1, latch `addr`=`BASE`, `remaining`=`COUNT` and `left`=`COUNT`, then set `BUSY`=1.
- **Zero-length burst.** `START` with `COUNT`=0 gives `BUSY`=1 for exactly one cycle, `DONE`=1 in that same cycle, and no `RE`.
- **START while busy.** `START` while `BUSY`=1 is ignored entirely.
- **Issue rule (combinational from registers).** `RE` = `BUSY` && `remaining`≠0 && (`fcount` + `inflight`) < 3. `RADDR` = `addr` at all times.
- **On an issue:**
  - `addr` increments, wrapping to 0 after DEPTH-1. Non-power-of-two DEPTH wraps explicitly at DEPTH-1, not at 2^AW.
  - `remaining` decrements by 1.
- **Capture.** When `inflight`=1, `RDATA` is pushed into the FIFO that cycle. Push and pop may occur in the same cycle; `fcount` is then unchanged.
- **Stream output.**
  - `OUT_VALID` = (`fcount` ≠ 0) and `OUT_DATA` = FIFO head.
  - Pop on `OUT_VALID` && `OUT_READY`; each pop decrements `left`.
  - Once asserted, `OUT_VALID` and `OUT_DATA` stay stable until the handshake.
- **FIFO never overflows.** The credit rule guarantees this; overflow is an assertion failure.
- **Completion.** The cycle the pop takes `left` from 1 to 0: `DONE`=1 (combinational with that handshake). `BUSY` drops at the following edge. A new `START` is accepted from the next cycle.
- **Reset.** `RESET`=1 at any time, including mid-burst, clears everything: `BUSY`=0, `DONE`=0, `RE`=0, `RADDR`=0, `OUT_VALID`=0, `fcount`=0, `inflight`=0. A read in flight at reset is discarded.

## Timing
- **Reset values:** `BUSY`=0, `DONE`=0, `RE`=0, `RADDR`=0, `OUT_VALID`=0, `OUT_DATA`=0 (FIFO storage is not reset).
- **Burst latency**, with `START` accepted at edge E0:
  - cycle 1: `BUSY`=1, `RE`=1, `RADDR`=`BASE`.
  - cycle 2: `RDATA` holds mem[`BASE`] and is pushed.
  - cycle 3: `OUT_VALID`=1 with mem[`BASE`].
- **Throughput.** With `OUT_READY` held at 1, one word per cycle from cycle 3 onward. A burst of N≥1 gives `DONE` in cycle N+2 and `BUSY`=0 in cycle N+3.
- **Backpressure.** With `OUT_READY` held at 0, at most 3 reads are issued before `RE` stalls. `RE` resumes the cycle after the first pop, because `fcount` decreases at that edge.
- **No combinational path** from `OUT_READY` to `RE` or `RADDR`.

## Test plan
Memory init {5,0,21,11} at addresses 0..3 (the `Memory` wrapper contents), DEPTH=4, WIDTH=5.
- **Full burst:** `START` `BASE`=0, `COUNT`=4, `OUT_READY`=1 → stream 5,0,21,11 in cycles 3..6; `DONE` pulses in cycle 6; `BUSY` low in cycle 7.
- **Wrap:** `BASE`=3, `COUNT`=3 → `RADDR` sequence 3,0,1; stream 11,5,0.
- **Backpressure:** `BASE`=0, `COUNT`=4, `OUT_READY`=0 until cycle 10, then 1 → exactly 3 `RE` pulses before the stall; `OUT_DATA` held at 5; total stream 5,0,21,11 with no loss or duplication.
- **Zero count / ignored START:** `COUNT`=0 → `DONE` in cycle 1, no `RE`, no `OUT_VALID`. Second `START` with `BASE`=2 pulsed mid-burst → ignored; the first stream is unchanged.
- **Reset mid-burst:** `RESET` asserted in cycle 4 of a `COUNT`=4 burst → the next cycle shows all outputs at reset values. A fresh `START` `BASE`=1, `COUNT`=2 → stream 0,21 only.
- **Random ready:** random `OUT_READY` over 50 random bursts → the scoreboard matches memory contents with wrap, and FIFO occupancy never exceeds 3.

Source files
------------

// File: rtl/sync_mem_stream_reader.sv
// rtl/sync_mem_stream_reader.sv - burst read sequencer for a one-cycle-latency synchronous memory
// Issues credit-limited reads and drains the returned words through a 3-entry valid/ready FIFO.
module sync_mem_stream_reader #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [AW-1:0]    BASE,
  input  logic [CW-1:0]    COUNT,
  output logic             BUSY,
  output logic             DONE,
  output logic [AW-1:0]    RADDR,
  output logic             RE,
  input  logic [WIDTH-1:0] RDATA,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t           state, state_next;
  logic [AW-1:0]    addr;
  logic [CW-1:0]    remaining;
  logic [CW-1:0]    left;
  logic             inflight;
  logic [WIDTH-1:0] fifo [3];
  logic [1:0]       rd_ptr, wr_ptr, fcount;
  logic             push, pop, issue, start_accept;

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
    return (a == AW'(DEPTH - 1)) ? '0 : a + AW'(1);
  endfunction

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign push      = inflight;
  assign OUT_VALID = (fcount != 2'd0);
  assign pop       = OUT_VALID && OUT_READY;
  assign OUT_DATA  = OUT_VALID ? fifo[rd_ptr] : '0;
  assign BUSY      = (state == S_BUSY);
  assign RADDR     = addr;
  assign RE        = issue;

  always_comb begin
    state_next   = state;
    issue        = 1'b0;
    DONE         = 1'b0;
    start_accept = 1'b0;
    case (state)
      S_IDLE: begin
        if (START) begin
          start_accept = 1'b1;
          state_next   = S_BUSY;
        end
      end
      S_BUSY: begin
        // Credit counts the word already in flight, so the FIFO can always absorb it.
        issue = (remaining != '0) && (({1'b0, fcount} + {2'b00, inflight}) < 3'd3);
        if ((left == '0) || (pop && (left == CW'(1)))) begin
          DONE       = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= S_IDLE;
      addr      <= '0;
      remaining <= '0;
      left      <= '0;
      inflight  <= 1'b0;
      rd_ptr    <= 2'd0;
      wr_ptr    <= 2'd0;
      fcount    <= 2'd0;
    end else begin
      state    <= state_next;
      inflight <= issue;
      if (start_accept) begin
        addr      <= BASE;
        remaining <= COUNT;
        left      <= COUNT;
      end else begin
        if (issue) begin
          addr      <= next_addr(addr);
          remaining <= remaining - CW'(1);
        end
        if (pop) left <= left - CW'(1);
      end
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   fcount <= fcount + 2'd1;
        2'b01:   fcount <= fcount - 2'd1;
        default: fcount <= fcount;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) fifo[wr_ptr] <= RDATA;
  end

  no_overflow: assert property (@(posedge CLK) disable iff (RESET)
    !(push && !pop && (fcount == 2'd3)));

endmodule
